// File: rtl/gps_cfg_sequencer.sv
// Control-plane sequencer for the GPS signal generator core.
// A byte-wide address/data stream fills shadow registers. A commit arms an
// atomic copy of the shadow parameters into the active outputs, and that copy
// only happens at a C/A code-epoch boundary. The navigation message bit stream
// is generated alongside and reloads its word only at word boundaries.
module gps_cfg_sequencer #(
    parameter int                 CODE_LEN       = 16368,
    parameter int                 EPOCHS_PER_BIT = 20,
    parameter int                 MSG_BITS       = 32,
    parameter logic [MSG_BITS-1:0] MSG_PRESET    = 32'hFEEDCAFE
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        ena_in,
    input  logic        cfg_valid_in,
    input  logic [7:0]  cfg_data_in,
    output logic        cfg_ready_out,
    output logic [4:0]  n_sat_out,
    output logic [15:0] ca_phase_out,
    output logic [7:0]  doppler_out,
    output logic [7:0]  snr_out,
    output logic        noise_off_out,
    output logic        signal_off_out,
    output logic        msg_out,
    output logic        epoch_out,
    output logic        bit_edge_out,
    output logic        pending_out,
    output logic        err_out
);

    // ------------------------------------------------------------------
    // Widths and terminal counts
    // ------------------------------------------------------------------
    localparam int CNT_W     = (CODE_LEN > 1)       ? $clog2(CODE_LEN)       : 1;
    localparam int BIT_W     = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;
    localparam int IDX_W     = (MSG_BITS > 1)       ? $clog2(MSG_BITS)       : 1;
    localparam int MSG_BYTES = MSG_BITS / 8;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CODE_LEN - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(EPOCHS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_BITS - 1);

    localparam logic [7:0] ADDR_NSAT   = 8'h00;
    localparam logic [7:0] ADDR_DOP    = 8'h01;
    localparam logic [7:0] ADDR_SNR    = 8'h02;
    localparam logic [7:0] ADDR_PH_LO  = 8'h03;
    localparam logic [7:0] ADDR_PH_HI  = 8'h04;
    localparam logic [7:0] ADDR_FLAGS  = 8'h05;
    localparam logic [7:0] ADDR_MSG0   = 8'h06;
    localparam logic [7:0] ADDR_MSG_LAST = 8'h09;
    localparam logic [7:0] ADDR_COMMIT = 8'h0F;

    // ------------------------------------------------------------------
    // Configuration FSM state
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_ADDR = 1'b0,
        ST_DATA = 1'b1
    } cfg_state_t;

    cfg_state_t  state_reg, state_next;
    logic [7:0]  addr_reg, addr_next;
    logic        cfg_ready;
    logic        wr_en;

    // Shadow parameters
    logic [4:0]  n_sat_sh_reg;
    logic [7:0]  doppler_sh_reg;
    logic [7:0]  snr_sh_reg;
    logic [15:0] ca_phase_sh_reg;
    logic [1:0]  flags_sh_reg;
    logic [MSG_BITS-1:0] msg_sh_word;

    // Active parameters
    logic [4:0]  n_sat_reg;
    logic [7:0]  doppler_reg;
    logic [7:0]  snr_reg;
    logic [15:0] ca_phase_reg;
    logic [1:0]  flags_reg;

    logic        pending_reg;
    logic        err_reg;

    // Timing chain
    logic [CNT_W-1:0]    cnt_reg;
    logic [BIT_W-1:0]    bit_cnt_reg;
    logic [IDX_W-1:0]    bit_idx_reg;
    logic [MSG_BITS-1:0] msg_sr_reg;
    logic                epoch_reg;
    logic                bit_edge_reg;

    logic tick;
    logic btick;
    logic word_end;

    // Decoded write strobes
    logic commit_wr;
    logic err_wr;

    // ------------------------------------------------------------------
    // Strobes derived from the counters
    // ------------------------------------------------------------------
    assign tick     = ena_in && (cnt_reg == CNT_LAST);
    assign btick    = tick && (bit_cnt_reg == BIT_LAST);
    assign word_end = btick && (bit_idx_reg == IDX_LAST);

    assign commit_wr = wr_en && (addr_reg == ADDR_COMMIT);
    assign err_wr    = wr_en && (addr_reg > ADDR_MSG_LAST) && (addr_reg != ADDR_COMMIT);

    // FSM state and latched address register
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_reg <= ST_ADDR;
            addr_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
        end
    end

    // Next-state logic: address byte then data byte; a new address is refused while a commit is armed
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        cfg_ready  = 1'b1;
        wr_en      = 1'b0;
        case (state_reg)
            ST_ADDR: begin
                cfg_ready = ~pending_reg;
                if (cfg_valid_in && !pending_reg) begin
                    addr_next  = cfg_data_in;
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                cfg_ready = 1'b1;
                if (cfg_valid_in) begin
                    wr_en      = 1'b1;
                    state_next = ST_ADDR;
                end
            end
            default: begin
                state_next = ST_ADDR;
            end
        endcase
    end

    // Shadow parameter registers, written by the data phase
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            n_sat_sh_reg    <= 5'd0;
            doppler_sh_reg  <= 8'd0;
            snr_sh_reg      <= 8'd0;
            ca_phase_sh_reg <= 16'd0;
            flags_sh_reg    <= 2'd0;
        end else if (wr_en) begin
            case (addr_reg)
                ADDR_NSAT:  n_sat_sh_reg           <= cfg_data_in[4:0];
                ADDR_DOP:   doppler_sh_reg         <= cfg_data_in;
                ADDR_SNR:   snr_sh_reg             <= cfg_data_in;
                ADDR_PH_LO: ca_phase_sh_reg[7:0]   <= cfg_data_in;
                ADDR_PH_HI: ca_phase_sh_reg[15:8]  <= cfg_data_in;
                ADDR_FLAGS: flags_sh_reg           <= cfg_data_in[1:0];
                default: ;
            endcase
        end
    end

    // Message shadow bytes, most significant byte at the lowest message address
    generate
        for (genvar gi = 0; gi < MSG_BYTES; gi++) begin : g_msg_byte
            logic [7:0] byte_reg;

            // One message shadow byte
            always_ff @(posedge clk_in or negedge rst_in_n) begin
                if (!rst_in_n) begin
                    byte_reg <= MSG_PRESET[MSG_BITS-1-8*gi -: 8];
                end else if (wr_en && (addr_reg == 8'(ADDR_MSG0 + gi))) begin
                    byte_reg <= cfg_data_in;
                end
            end

            assign msg_sh_word[MSG_BITS-1-8*gi -: 8] = byte_reg;
        end
    endgenerate

    // Commit arming: a commit in a tick cycle wins, so it waits for the following epoch
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            pending_reg <= 1'b0;
        end else if (commit_wr) begin
            pending_reg <= 1'b1;
        end else if (tick) begin
            pending_reg <= 1'b0;
        end
    end

    // Atomic copy of the shadow parameters into the active set at the epoch boundary
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            n_sat_reg    <= 5'd0;
            doppler_reg  <= 8'd0;
            snr_reg      <= 8'd0;
            ca_phase_reg <= 16'd0;
            flags_reg    <= 2'd0;
        end else if (tick && pending_reg) begin
            n_sat_reg    <= n_sat_sh_reg;
            doppler_reg  <= doppler_sh_reg;
            snr_reg      <= snr_sh_reg;
            ca_phase_reg <= ca_phase_sh_reg;
            flags_reg    <= flags_sh_reg;
        end
    end

    // Sticky flag for writes to unmapped addresses
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            err_reg <= 1'b0;
        end else if (err_wr) begin
            err_reg <= 1'b1;
        end
    end

    // Code-epoch counter, frozen while the sample enable is low
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            cnt_reg <= '0;
        end else if (ena_in) begin
            cnt_reg <= tick ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    // Epochs-per-bit counter, advanced once per code epoch
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            bit_cnt_reg <= '0;
        end else if (tick) begin
            bit_cnt_reg <= (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + BIT_W'(1);
        end
    end

    // Message shifter: shift MSB-first, reload the shadow word after the last bit
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            msg_sr_reg  <= MSG_PRESET;
            bit_idx_reg <= '0;
        end else if (word_end) begin
            msg_sr_reg  <= msg_sh_word;
            bit_idx_reg <= '0;
        end else if (btick) begin
            msg_sr_reg  <= {msg_sr_reg[MSG_BITS-2:0], 1'b0};
            bit_idx_reg <= bit_idx_reg + IDX_W'(1);
        end
    end

    // Registered boundary pulses, one cycle after the wrap cycle
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            epoch_reg    <= 1'b0;
            bit_edge_reg <= 1'b0;
        end else begin
            epoch_reg    <= tick;
            bit_edge_reg <= btick;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cfg_ready_out  = cfg_ready;
    assign n_sat_out      = n_sat_reg;
    assign ca_phase_out   = ca_phase_reg;
    assign doppler_out    = doppler_reg;
    assign snr_out        = snr_reg;
    assign noise_off_out  = flags_reg[1];
    assign signal_off_out = flags_reg[0];
    assign msg_out        = msg_sr_reg[MSG_BITS-1];
    assign epoch_out      = epoch_reg;
    assign bit_edge_out   = bit_edge_reg;
    assign pending_out    = pending_reg;
    assign err_out        = err_reg;

endmodule
